// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: state encodings, widths and defaults.
package fetch_pc_sequencer_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [PC_W-1:0] DEF_PC_STEP      = 16'd4;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_pc_increment_adder.sv
// Combinational sequential-PC adder; wraps modulo 2^PC_W with no carry out.
module pc_increment_adder
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_STEP = DEF_PC_STEP
) (
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_next_o
);

  assign pc_next_o = pc_i + PC_STEP;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch front end: PC, imem read handshake, valid/ready hand-off to decode.
// Define PC_DELAY_SLOT_EN for MIPS branch-delay-slot redirect semantics (default: flush).
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [PC_W-1:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              clr,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic              err_misaligned
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   redir_pc;
  logic              redir_act;
  logic              fetch_done;
`ifdef PC_DELAY_SLOT_EN
  logic              pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
`endif

  pc_increment_adder #(
    .PC_STEP(PC_STEP)
  ) u_pc_increment_adder (
    .pc_i      (pc_q),
    .pc_next_o (pc_inc)
  );

  assign redir_pc   = align_pc(redirect_target);
  assign redir_act  = redirect_valid && (state_q != S_RESET);
  assign fetch_done = (state_q == S_REQ) && imem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    req_d       = req_q;
    valid_d     = valid_q;
    err_d       = err_q;
`ifdef PC_DELAY_SLOT_EN
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
`endif

    case (state_q)
      S_RESET: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (imem_ack) begin
          inst_data_d = imem_rdata;
          inst_pc_d   = pc_q;
          valid_d     = 1'b1;
          pc_d        = pc_inc;
          req_d       = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_RESET;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    if (redir_act) begin
      err_d = err_q | (redirect_target[1:0] != 2'b00);
    end

`ifdef PC_DELAY_SLOT_EN
    // The fetch completing now is the delay slot, so it takes the branch target;
    // a redirect arriving on that same ack is applied directly instead of queued.
    if (fetch_done) begin
      if (redirect_valid) begin
        pc_d = redir_pc;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end
      pend_valid_d = 1'b0;
    end else if (redir_act) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redir_pc;
    end
`else
    // Redirect overrides everything, including a same-cycle ack or ready.
    if (redir_act) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      req_d   = 1'b1;
      state_d = S_REQ;
      if (fetch_done) begin
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_VECTOR;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
`ifdef PC_DELAY_SLOT_EN
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
`endif
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign err_misaligned = err_q;

endmodule
